seq_decoder: RTL

Registered, parametrised N-to-2^N line decoder with a valid/ready handshake on both input and output. It is the successor to the combinational 2-to-4 decoder. It adds configurable select width, output polarity, and two output modes: level (latched) and pulse (stretched for a fixed number of cycles). It sits between a control source issuing select codes and downstream enable/strobe lines.

---
 rtl/seq_decoder_pkg.sv | 26 ++
 rtl/dec_pulse_timer.sv | 37 +++
 rtl/seq_decoder.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/seq_decoder_pkg.sv
// -----------------------------------------------------------------------------
// seq_decoder_pkg
// Shared definitions for the registered line decoder:
//   state_t     - FSM state encodings (IDLE/HOLD/PULSE/DRAIN)
//   MODE_LEVEL  - latched one-hot output until the next code
//   MODE_PULSE  - one-hot asserted for a fixed number of cycles
//   onehot()    - bit idx of the one-hot code for sel
// -----------------------------------------------------------------------------
package seq_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    PULSE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_PULSE = 1'b1;

  // Evaluated per output bit so the caller's vector width stays parametric.
  function automatic logic onehot(input int sel, input int idx);
    return (sel == idx);
  endfunction

endpackage : seq_decoder_pkg

// File: rtl/dec_pulse_timer.sv
// -----------------------------------------------------------------------------
// dec_pulse_timer
// Loadable down-counter timing the pulse-mode one-hot.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load value into the counter (wins over counting)
//   value      : load value, normally PULSE_LEN-1
//   done       : counter is at zero
// The counter holds at zero, so it can never wrap below zero.
// -----------------------------------------------------------------------------
module dec_pulse_timer #(
  parameter int PULSE_LEN = 4,
  localparam int CNT_W    = $clog2(PULSE_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule : dec_pulse_timer

// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
// Registered N-to-2^N line decoder with valid/ready handshakes.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : allows new codes to be accepted
//   mode       : 0 = level (latched), 1 = pulse; sampled on accept
//   in_valid   : in_sel carries a code
//   in_sel     : code to decode
//   in_ready   : block can accept a code this cycle
//   out_valid  : decode event awaiting acknowledgement
//   out_ready  : downstream acknowledges the event
//   dec_out    : registered one-hot, inverted when ACTIVE_LOW
//   busy       : FSM not idle
// -----------------------------------------------------------------------------
module seq_decoder
  import seq_decoder_pkg::*;
#(
  parameter int  SEL_W      = 2,
  parameter int  PULSE_LEN  = 4,
  parameter bit  ACTIVE_LOW = 1'b0,
  localparam int OUT_W      = 2 ** SEL_W,
  localparam int CNT_W      = $clog2(PULSE_LEN) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dec_out,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             mode_q, mode_d;
  logic             have_val_q, have_val_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] dec_q, dec_d;
  logic [OUT_W-1:0] dec_act;
  logic             accept;
  logic             timer_done;

  assign accept = in_valid && in_ready;

  dec_pulse_timer #(
    .PULSE_LEN (PULSE_LEN)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .value (CNT_W'(PULSE_LEN - 1)),
    .done  (timer_done)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = (mode == MODE_PULSE) ? PULSE : HOLD;
      end
      HOLD: begin
        // Ack together with a new code reloads in the same cycle.
        if (accept)         state_d = (mode == MODE_PULSE) ? PULSE : HOLD;
        else if (out_ready) state_d = IDLE;
      end
      PULSE: begin
        // The pulse runs its full length; only the exit depends on the ack.
        if (timer_done) state_d = (!out_valid_q || out_ready) ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = en;
      HOLD:    in_ready = en && out_ready;
      default: in_ready = 1'b0;
    endcase

    busy = (state_q != IDLE);

    sel_d       = accept ? in_sel : sel_q;
    mode_d      = accept ? mode   : mode_q;
    have_val_d  = accept ? 1'b1   : have_val_q;
    out_valid_d = accept ? 1'b1   : (out_ready ? 1'b0 : out_valid_q);

    for (int i = 0; i < OUT_W; i++) begin
      dec_act[i] = onehot(32'(sel_d), i);
    end

    // dec_out is registered, so it is computed from the state being entered.
    dec_d = {OUT_W{ACTIVE_LOW}};
    if (state_d == HOLD || state_d == PULSE ||
        (state_d == IDLE && have_val_d && mode_d == MODE_LEVEL)) begin
      dec_d = ACTIVE_LOW ? ~dec_act : dec_act;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q       <= '0;
      mode_q      <= MODE_LEVEL;
      have_val_q  <= 1'b0;
      out_valid_q <= 1'b0;
      dec_q       <= {OUT_W{ACTIVE_LOW}};
    end else begin
      sel_q       <= sel_d;
      mode_q      <= mode_d;
      have_val_q  <= have_val_d;
      out_valid_q <= out_valid_d;
      dec_q       <= dec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dec_out   = dec_q;

endmodule : seq_decoder
